overlap_add_address_manager: RTL
================================

Name: overlap_add_address_manager

Overview:
- Synthesis-side counterpart to the analysis window FIFO. Generates addresses and control for the overlap-add (OLA) accumulation RAM that rebuilds the time-domain stream from processed, windowed frames.
- Frames of N = 2^ADDRWIDTH samples arrive one sample per accept at 50% overlap (HOP = N/2).
- First half of each frame is added to the previous frame's tail; second half is written fresh.
- Each completed HOP-sample segment is released to the output reader.
- Sits between the post-IFFT windowing stage and the output sample FIFO/DAC path. Manages addresses only; the adder and RAM live outside.

Parameters:
- ADDRWIDTH, 12, log2 of the frame length N. RAM depth is N. HOP = 2^(ADDRWIDTH-1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enqueue  in  1  frame sample offered by the upstream stage.
- full  out  1  sample cannot be accepted this cycle.
- dequeue  in  1  output reader requests one finished sample.
- empty  out  1  no finished sample is available.
- acc_read_addr  out  ADDRWIDTH  RAM read address for the sample being accepted this cycle (combinational).
- write_addr  out  ADDRWIDTH  RAM write address, registered; one cycle after accept.
- write_en  out  1  RAM write strobe, registered; one cycle after accept.
- accumulate  out  1  qualifies write_en. 1 = write RAM read data + sample; 0 = write the sample alone.
- read_addr  out  ADDRWIDTH  output read address (current read pointer).
- window_addr  out  ADDRWIDTH  index of the next sample within the current frame (drives the synthesis window LUT).

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - win_idx=0, base=0, rd_ptr=0, avail=0, first_frame=1.
  - write_en=0, accumulate=0, write_addr=0, read_addr=0, window_addr=0.
  - Resulting outputs: empty=1, full=0.
  - Any partial frame is discarded; no RAM clear is needed.
- Internal state:
  - win_idx[AW-1:0], base[AW-1:0], rd_ptr[AW-1:0].
  - avail[AW:0], range 0..N.
  - first_frame, pend_pub.
- Accept on enq_acc = enqueue & !full.
  - acc_read_addr = (base + win_idx) mod N. Wraps naturally at AW bits.
- On enq_acc:
  - Next cycle: write_en=1, write_addr=acc_read_addr, accumulate = (win_idx < HOP) & !first_frame.
  - win_idx increments.
  - At win_idx==N-1: win_idx→0, base→base+HOP mod N, first_frame→0.
  - At win_idx==HOP-1: pend_pub set for the following cycle.
- Publish:
  - In the cycle where pend_pub=1 (that segment's final write is occurring), avail += HOP at the end of the cycle.
  - Samples become readable the cycle after the RAM write.
  - empty therefore deasserts 2 cycles after accepting index HOP-1.
- Overwrite protection: full = (win_idx==HOP) & (pend_pub | avail > HOP).
  - Guarantees the previous segment, which the second half overwrites, is fully drained first.
  - Costs at least one stall cycle per frame (the pend_pub cycle).
  - full is never asserted at any other index.
- Dequeue on deq_acc = dequeue & !empty, where empty = (avail==0).
  - read_addr = rd_ptr; rd_ptr→rd_ptr+1 mod N; avail decrements.
  - RAM read data follows per the RAM's own latency.
- Simultaneous publish and dequeue in the same cycle: avail += HOP-1.
- avail never exceeds N; the stall rule enforces this, and the bench asserts it.
- window_addr = win_idx, held while full is asserted.
- Two consecutive writes never target the same address, because N ≥ 4. No RAM read-after-write hazard exists inside the manager.

Decomposition:
- Shared package ola_pkg holds:
  - ADDRWIDTH default, WINDOW_LEN = 2^ADDRWIDTH, HOP = WINDOW_LEN/2.
  - The avail width rule (ADDRWIDTH+1).
- One sub-module, ola_avail_counter: the up-by-HOP / down-by-1 saturating-checked counter producing avail, empty and the avail>HOP compare.
- All other logic is flat in the top.

Test Plan (ADDRWIDTH=3: N=8, HOP=4):
- Reset → empty=1, full=0, write_en=0, window_addr=0, read_addr=0. Assert reset mid-frame at win_idx=5 → all state zeroes immediately, asynchronously.
- Frame 0, enqueue held high, no dequeue:
  - acc_read_addr 0,1,2,3 accepted, each followed by write_en=1, accumulate=0.
  - full=1 for exactly 1 cycle at index 4.
  - Then addresses 4..7 are accepted with accumulate=0.
  - empty falls 2 cycles after accept of index 3; avail=4.
- Frame 1, no dequeue:
  - acc_read_addr 4,5,6,7 with accumulate=1; avail becomes 8.
  - full stays 1 at index 4.
  - Four dequeues give read_addr 0,1,2,3; full drops the cycle after avail reaches 4.
  - Frame 1's second half then writes 0..3 with accumulate=0.
- Wrap: frame 2 has base=0. Addresses 0..3 get accumulate=1, 4..7 get accumulate=0. rd_ptr wraps 7→0 correctly.
- Publish with dequeue in the same cycle: avail=3 before → avail=6 after.
- Dequeue while empty=1 → no change to read_addr or avail. Enqueue while full=1 → no change to window_addr, no write_en.

Source files
------------

// File: rtl/ola_pkg.sv
// Shared constants and sizing helpers for the overlap-add address manager.
// Frame length is 2^ADDRWIDTH samples; frames overlap by half (HOP).
package ola_pkg;

    localparam int ADDRWIDTH_DEFAULT = 12;

    // Frame length for a given address width.
    function automatic int window_len(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Hop (half frame) for a given address width.
    function automatic int hop_len(input int addr_width);
        return window_len(addr_width) / 2;
    endfunction

    // The availability count must hold 0..N inclusive, so it needs one extra bit.
    function automatic int avail_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int WINDOW_LEN = window_len(ADDRWIDTH_DEFAULT);
    localparam int HOP        = WINDOW_LEN / 2;

endpackage

// File: rtl/overlap_add_address_manager_if.sv
// Sample handshake and RAM address bus of the overlap-add address manager.
// The manager is the slave; the surrounding datapath is the master.
interface overlap_add_address_manager_if #(
    parameter int ADDRWIDTH = ola_pkg::ADDRWIDTH_DEFAULT
);

    logic                 enqueue;
    logic                 full;
    logic                 dequeue;
    logic                 empty;
    logic [ADDRWIDTH-1:0] acc_read_addr;
    logic [ADDRWIDTH-1:0] write_addr;
    logic                 write_en;
    logic                 accumulate;
    logic [ADDRWIDTH-1:0] read_addr;
    logic [ADDRWIDTH-1:0] window_addr;

    modport slave (
        input  enqueue, dequeue,
        output full, empty, acc_read_addr, write_addr, write_en, accumulate,
               read_addr, window_addr
    );

    modport master (
        output enqueue, dequeue,
        input  full, empty, acc_read_addr, write_addr, write_en, accumulate,
               read_addr, window_addr
    );

endinterface

// File: rtl/ola_avail_counter.sv
// Count of finished output samples: up by HOP when a segment is published,
// down by one per accepted dequeue. Also reports empty and avail > HOP,
// which the top uses to hold off overwriting an undrained segment.
module ola_avail_counter
    import ola_pkg::*;
#(
    parameter int ADDRWIDTH = ADDRWIDTH_DEFAULT,
    parameter int DEPTH     = WINDOW_LEN,
    parameter int HOP_LEN   = HOP
) (
    input  logic clock,
    input  logic reset,
    input  logic publish,
    input  logic dequeue,
    output logic empty,
    output logic above_hop,
    output logic deq_acc
);

    localparam int                 AVAIL_W   = avail_width(ADDRWIDTH);
    localparam logic [AVAIL_W:0]   DEPTH_EXT = (AVAIL_W + 1)'(DEPTH);
    localparam logic [AVAIL_W:0]   HOP_EXT   = (AVAIL_W + 1)'(HOP_LEN);
    localparam logic [AVAIL_W:0]   ONE_EXT   = (AVAIL_W + 1)'(1);

    logic [AVAIL_W-1:0] avail;
    logic [AVAIL_W:0]   sum;

    assign empty     = (avail == '0);
    assign deq_acc   = dequeue & ~empty;
    assign above_hop = ({1'b0, avail} > HOP_EXT);

    // Next count, computed one bit wider so an overshoot is visible.
    always_comb begin
        // NOTE: assign a default first so every path drives sum and no latch is inferred.
        sum = {1'b0, avail};
        if (publish) sum = sum + HOP_EXT;
        if (deq_acc) sum = sum - ONE_EXT;
    end

    // Register the count, clamped at N; the stall rule keeps the clamp inactive.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            avail <= '0;
        end else if (sum > DEPTH_EXT) begin
            avail <= DEPTH_EXT[AVAIL_W-1:0];
        end else begin
            avail <= sum[AVAIL_W-1:0];
        end
    end

endmodule

// File: rtl/overlap_add_address_manager.sv
// Address and control generator for the overlap-add accumulation RAM.
// Each frame's first half is accumulated onto the previous frame's tail,
// the second half is written fresh, and every completed HOP-sample segment
// is handed to the output reader.
module overlap_add_address_manager
    import ola_pkg::*;
#(
    parameter int ADDRWIDTH = ADDRWIDTH_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    overlap_add_address_manager_if.slave bus
);

    localparam logic [ADDRWIDTH-1:0] HOP_IDX  = ADDRWIDTH'(hop_len(ADDRWIDTH));
    localparam logic [ADDRWIDTH-1:0] HOP_LAST = ADDRWIDTH'(hop_len(ADDRWIDTH) - 1);
    localparam logic [ADDRWIDTH-1:0] LAST_IDX = '1;
    localparam logic [ADDRWIDTH-1:0] ONE      = ADDRWIDTH'(1);

    logic [ADDRWIDTH-1:0] win_idx;
    logic [ADDRWIDTH-1:0] base;
    logic [ADDRWIDTH-1:0] rd_ptr;
    logic [ADDRWIDTH-1:0] acc_addr;
    logic [ADDRWIDTH-1:0] write_addr_q;
    logic                 write_en_q;
    logic                 accumulate_q;
    logic                 first_frame;
    logic                 pend_pub;
    logic                 full_int;
    logic                 empty_int;
    logic                 above_hop;
    logic                 deq_acc;
    logic                 enq_acc;

    ola_avail_counter #(
        .ADDRWIDTH (ADDRWIDTH),
        .DEPTH     (window_len(ADDRWIDTH)),
        .HOP_LEN   (hop_len(ADDRWIDTH))
    ) u_avail (
        .clock     (clock),
        .reset     (reset),
        .publish   (pend_pub),
        .dequeue   (bus.dequeue),
        .empty     (empty_int),
        .above_hop (above_hop),
        .deq_acc   (deq_acc)
    );

    // Stall only at the start of the second half, until the segment it will
    // overwrite has been published and drained to at most one HOP.
    assign full_int = (win_idx == HOP_IDX) & (pend_pub | above_hop);
    assign enq_acc  = bus.enqueue & ~full_int;
    assign acc_addr = base + win_idx;

    assign bus.full          = full_int;
    assign bus.empty         = empty_int;
    assign bus.acc_read_addr = acc_addr;
    assign bus.write_addr    = write_addr_q;
    assign bus.write_en      = write_en_q;
    assign bus.accumulate    = accumulate_q;
    assign bus.read_addr     = rd_ptr;
    assign bus.window_addr   = win_idx;

    // Frame position: advance per accepted sample, step base by HOP per frame.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            win_idx     <= '0;
            base        <= '0;
            first_frame <= 1'b1;
        end else if (enq_acc) begin
            if (win_idx == LAST_IDX) begin
                win_idx     <= '0;
                base        <= base + HOP_IDX;
                first_frame <= 1'b0;
            end else begin
                win_idx <= win_idx + ONE;
            end
        end
    end

    // RAM write strobe, address and mode, one cycle after accept; flag the
    // cycle in which the last write of a segment lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_en_q   <= 1'b0;
            accumulate_q <= 1'b0;
            write_addr_q <= '0;
            pend_pub     <= 1'b0;
        end else begin
            write_en_q   <= enq_acc;
            accumulate_q <= enq_acc & (win_idx < HOP_IDX) & ~first_frame;
            pend_pub     <= enq_acc & (win_idx == HOP_LAST);
            if (enq_acc) begin
                write_addr_q <= acc_addr;
            end
        end
    end

    // Output read pointer, wrapping naturally at N.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (deq_acc) begin
            rd_ptr <= rd_ptr + ONE;
        end
    end

endmodule
